// File: rtl/line_buffer_sequencer.sv
// Row-rate sequencer for the scanline ring buffer: chooses scan-out and render buffers,
// issues toggle-tagged render requests, and repeats the last good line on underrun.
module line_buffer_sequencer #(
  parameter int NUM_BUFS    = 2,
  parameter int PRIME_LINES = 1,
  parameter int V_LINES     = 525,
  parameter int V_VISIBLE   = 480,
  parameter int Y_W         = 10,
  localparam int SEL_W      = (NUM_BUFS > 2) ? $clog2(NUM_BUFS) : 1
) (
  input  logic             row_Clk,
  input  logic             Reset,
  input  logic             enable,
  input  logic             done_tag,
  output logic [Y_W-1:0]   line_Y,
  output logic [SEL_W-1:0] read_sel,
  output logic [Y_W-1:0]   write_Y,
  output logic [SEL_W-1:0] write_sel,
  output logic             write_tag,
  output logic             write_busy,
  output logic             frame_start,
  output logic             underrun,
  output logic [15:0]      underrun_cnt,
  output logic             running
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  localparam logic [Y_W-1:0]   Y_ONE         = Y_W'(1);
  localparam logic [Y_W-1:0]   Y_VIS         = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0]   Y_VIS_LAST    = Y_W'(V_VISIBLE - 1);
  localparam logic [Y_W-1:0]   Y_LAST        = Y_W'(V_LINES - 1);
  localparam logic [SEL_W-1:0] SEL_ONE       = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST      = SEL_W'(NUM_BUFS - 1);
  localparam logic [3:0]       OCC_PRIME     = 4'(PRIME_LINES);
  localparam logic [3:0]       OCC_ISSUE_MAX = 4'(NUM_BUFS - 2);

  state_t           state_q, state_d;
  logic [3:0]       occ_q, occ_d, occ_n, occ_eff;
  logic [Y_W-1:0]   line_Y_q, line_Y_d, ly_next, wy_inc;
  logic [SEL_W-1:0] read_sel_q, read_sel_d, rs_inc;
  logic [Y_W-1:0]   write_Y_q, write_Y_d;
  logic [SEL_W-1:0] write_sel_q, write_sel_d, ws_inc;
  logic             write_tag_q, write_tag_d;
  logic             write_busy_q, write_busy_d;
  logic             frame_start_q, frame_start_d;
  logic             underrun_q, underrun_d;
  logic [15:0]      underrun_cnt_q, underrun_cnt_d;
  logic             done, try_issue;

  assign done    = write_busy_q && (done_tag == write_tag_q);
  assign occ_eff = occ_q + {3'b000, done};
  assign ly_next = (line_Y_q == Y_LAST) ? '0 : line_Y_q + Y_ONE;
  assign wy_inc  = (write_Y_q == Y_VIS_LAST) ? '0 : write_Y_q + Y_ONE;
  assign rs_inc  = (read_sel_q == SEL_LAST) ? '0 : read_sel_q + SEL_ONE;
  assign ws_inc  = (write_sel_q == SEL_LAST) ? '0 : write_sel_q + SEL_ONE;

  always_comb begin
    state_d        = state_q;
    line_Y_d       = line_Y_q;
    read_sel_d     = read_sel_q;
    write_Y_d      = write_Y_q;
    write_sel_d    = write_sel_q;
    write_tag_d    = write_tag_q;
    write_busy_d   = write_busy_q;
    underrun_cnt_d = underrun_cnt_q;
    frame_start_d  = 1'b0;
    underrun_d     = 1'b0;
    occ_n          = occ_eff;
    try_issue      = 1'b0;
    occ_d          = occ_q;
    if (!enable) begin
      state_d      = IDLE;
      occ_d        = '0;
      line_Y_d     = '0;
      read_sel_d   = '0;
      write_Y_d    = '0;
      write_sel_d  = '0;
      write_tag_d  = 1'b0;
      write_busy_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = PRIME;
          occ_n        = '0;
          write_Y_d    = '0;
          write_sel_d  = '0;
          write_tag_d  = ~write_tag_q;
          write_busy_d = 1'b1;
        end
        PRIME: begin
          if (occ_eff == OCC_PRIME) begin
            state_d       = RUN;
            line_Y_d      = '0;
            read_sel_d    = '0;
            occ_n         = occ_eff - 4'd1;
            frame_start_d = 1'b1;
          end
          try_issue = 1'b1;
        end
        RUN: begin
          line_Y_d      = ly_next;
          frame_start_d = (ly_next == '0);
          if (ly_next < Y_VIS) begin
            if (occ_eff != 4'd0) begin
              read_sel_d = rs_inc;
              occ_n      = occ_eff - 4'd1;
              try_issue  = 1'b1;
            end else begin
              // Stale line shown: drop the late request and aim at the line after this one.
              underrun_d     = 1'b1;
              occ_n          = '0;
              underrun_cnt_d = (underrun_cnt_q == 16'hFFFF) ? underrun_cnt_q
                                                            : underrun_cnt_q + 16'd1;
              write_tag_d    = ~write_tag_q;
              write_busy_d   = 1'b1;
              write_Y_d      = (ly_next == Y_VIS_LAST) ? '0 : ly_next + Y_ONE;
            end
          end else begin
            try_issue = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
      occ_d = occ_n;
      if (try_issue && (!write_busy_q || done)) begin
        if (occ_n <= OCC_ISSUE_MAX) begin
          write_tag_d  = ~write_tag_q;
          write_busy_d = 1'b1;
          write_Y_d    = wy_inc;
          write_sel_d  = ws_inc;
        end else begin
          write_busy_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge row_Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      occ_q          <= '0;
      line_Y_q       <= '0;
      read_sel_q     <= '0;
      write_Y_q      <= '0;
      write_sel_q    <= '0;
      write_tag_q    <= 1'b0;
      write_busy_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      occ_q          <= occ_d;
      line_Y_q       <= line_Y_d;
      read_sel_q     <= read_sel_d;
      write_Y_q      <= write_Y_d;
      write_sel_q    <= write_sel_d;
      write_tag_q    <= write_tag_d;
      write_busy_q   <= write_busy_d;
      frame_start_q  <= frame_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign line_Y       = line_Y_q;
  assign read_sel     = read_sel_q;
  assign write_Y      = write_Y_q;
  assign write_sel    = write_sel_q;
  assign write_tag    = write_tag_q;
  assign write_busy   = write_busy_q;
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign running      = (state_q == RUN);

endmodule
